alu_uart_host: RTL and testbench
================================

// Module: alu_uart_host
// PURPOSE
//  Host-side initiator for the UART-attached ALU system. Serialises operand A, operand B and the opcode as three
//  8N1 frames onto the line feeding the system's i_tx, then receives the single result frame from its o_rx.
//  Lives in the test/host harness (or a second FPGA); also serves as the reference stimulus engine for system sims.
// PARAMETERS
//  SIZEDATA       8      data byte width (operands, result)
//  SIZEOP         6      opcode width; zero-extended to SIZEDATA on the wire
//  TICK_DIV       163    clocks per 16x-oversample tick (50 MHz / (19200*16))
//  TIMEOUT_TICKS  4096   ticks allowed in WAIT_RES before giving up
// PORTS
//  i_clock     in   1         system clock
//  i_reset     in   1         asynchronous reset, active-low
//  i_start     in   1         request a transaction; sampled only when o_busy=0
//  i_datoa     in   SIZEDATA  operand A
//  i_datob     in   SIZEDATA  operand B
//  i_opcode    in   SIZEOP    ALU opcode
//  i_rx        in   1         serial line from system o_rx (asynchronous, idle high)
//  o_tx        out  1         serial line to system i_tx (idle high)
//  o_busy      out  1         transaction in progress
//  o_result    out  SIZEDATA  last good result byte
//  o_valid     out  1         1-cycle pulse: o_result updated
//  o_timeout   out  1         1-cycle pulse: no response in time
//  o_frame_err out  1         1-cycle pulse: result stop bit sampled low
// BEHAVIOUR
//  - Reset (i_reset=0, async): o_tx=1, o_busy=0, o_result=0, all pulses 0, FSM=IDLE, tick counter=0.
//  - Accept: i_start=1 in IDLE -> latch A, B, {0,opcode}; o_busy=1 next cycle. i_start while busy is ignored.
//  - FSM: IDLE -> SEND_A -> SEND_B -> SEND_OP -> WAIT_RES -> IDLE. Each SEND_x emits exactly one frame.
//  - Frame: start(0), d0..d7 LSB first, stop(1); every bit lasts 16 ticks (160 ticks/frame). The first start
//    bit begins on the first tick after accept. Frames are back-to-back with no idle gap.
//  - Rx: i_rx passes a 2-flop synchroniser. The receiver arms at the start of SEND_OP's stop bit; earlier falling
//    edges are ignored. Start is confirmed if still low at tick 7 after the falling edge (else re-arm);
//    data/stop are sampled every 16 ticks thereafter (mid-bit).
//  - Response outcome:
//    - stop=1: o_result<=byte, o_valid pulse.
//    - stop=0: o_frame_err pulse, o_result unchanged.
//    - Either case: o_busy=0 and IDLE on the following cycle.
//  - Timeout: tick counter runs from entry to WAIT_RES and stops when a start is confirmed. Reaching
//    TIMEOUT_TICKS with no confirmed start -> o_timeout pulse, IDLE, o_result unchanged.
//  - A pulse and a new acceptance never coincide: i_start is honoured from the cycle after o_busy falls.
//  - The tick generator free-runs from reset; it is not restarted per frame.
//  - Reset mid-operation aborts immediately; no partial frame completes and o_tx returns high.
// STRUCTURE
//  - Shared package alu_uart_pkg: SIZEDATA/SIZEOP defaults, OVERSAMPLE=16, the FSM state encoding, ALU opcode
//    constants (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, XOR=6'h26, SRA=6'h03, SRL=6'h02, NOR=6'h27).
//  - Sub-module uart_tick_gen: mod-TICK_DIV counter producing a 1-cycle tick enable.
//  - FSM, tx shifter and rx sampler stay in this module.
// TESTING
//  1 Reset held low 5 cycles -> o_tx=1, o_busy=0, o_result=0x00, no pulses; o_tx stays 1 with i_start=0.
//  2 A=0x05, B=0x03, op=ADD; bench responder returns 0x08 -> o_tx carries 0x05,0x03,0x20 LSB-first at 160 ticks
//    each; single o_valid pulse with o_result=0x08; o_busy falls next cycle.
//  3 Silent responder -> o_timeout pulses exactly TIMEOUT_TICKS ticks after WAIT_RES entry; o_result unchanged.
//  4 Response 0x5A with stop bit forced 0 -> o_frame_err pulse, o_valid stays 0, o_result keeps previous value.
//  5 Glitch on i_rx (low 3 ticks) during WAIT_RES -> no capture, counter continues.
//    i_start pulsed during SEND_B -> ignored, exactly 3 frames sent.
//  6 End-to-end against the system top: A=0xF0, B=0x10, SUB -> o_result=0xE0;
//    reset asserted mid SEND_B -> o_tx=1 same cycle, clean transaction afterwards.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-attached ALU host: widths, oversample ratio, FSM states, opcodes.
package alu_uart_pkg;
  localparam int SIZEDATA_DEF = 8;
  localparam int SIZEOP_DEF   = 6;
  localparam int OVERSAMPLE   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_SEND_OP,
    ST_WAIT_RES
  } host_state_t;

  localparam logic [SIZEOP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [SIZEOP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [SIZEOP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [SIZEOP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [SIZEOP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [SIZEOP_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [SIZEOP_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [SIZEOP_DEF-1:0] OP_NOR = 6'h27;
endpackage

// File: rtl/uart_tick_gen.sv
// Free-running mod-TICK_DIV divider; tick is a registered 1-cycle enable every TICK_DIV clocks.
module uart_tick_gen #(
  parameter int TICK_DIV = 163
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_uart_host.sv
// Host initiator: sends A, B, opcode as 8N1 frames, then receives one result frame or times out.
module alu_uart_host
  import alu_uart_pkg::*;
#(
  parameter int SIZEDATA      = SIZEDATA_DEF,
  parameter int SIZEOP        = SIZEOP_DEF,
  parameter int TICK_DIV      = 163,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [SIZEDATA-1:0] i_datoa,
  input  logic [SIZEDATA-1:0] i_datob,
  input  logic [SIZEOP-1:0]   i_opcode,
  input  logic                i_rx,
  output logic                o_tx,
  output logic                o_busy,
  output logic [SIZEDATA-1:0] o_result,
  output logic                o_valid,
  output logic                o_timeout,
  output logic                o_frame_err
);
  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [3:0] SUB_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] START_CHK  = 4'(OVERSAMPLE / 2 - 2);
  localparam logic [3:0] TX_STOP    = 4'(SIZEDATA + 1);
  localparam logic [3:0] RX_STOP    = 4'(SIZEDATA);

  host_state_t state, state_nxt;
  logic tick;

  logic [SIZEDATA-1:0] reg_a, reg_b, reg_op;
  logic [SIZEDATA:0]   tx_frame;
  logic                tx_run;
  logic [3:0]          tx_bit, tx_sub;
  logic                frame_end;

  logic                rx_s1, rx_s2, rx_d;
  logic                rx_armed, rx_chk, rx_conf;
  logic [3:0]          rx_sub, rx_bit;
  logic [SIZEDATA-1:0] rx_byte;
  logic                rx_done;

  logic [TOW-1:0]      to_cnt;
  logic                to_hit;

  uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (i_clock),
    .rst_n (i_reset),
    .tick  (tick)
  );

  assign frame_end = tick && tx_run && (tx_sub == SUB_LAST) && (tx_bit == TX_STOP);
  assign rx_done   = tick && rx_conf && (rx_sub == SUB_LAST) && (rx_bit == RX_STOP);
  assign to_hit    = tick && (state == ST_WAIT_RES) && !rx_conf && (to_cnt == TOW'(TIMEOUT_TICKS - 1));
  assign o_busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (i_start) state_nxt = ST_SEND_A;
      ST_SEND_A:   if (frame_end) state_nxt = ST_SEND_B;
      ST_SEND_B:   if (frame_end) state_nxt = ST_SEND_OP;
      ST_SEND_OP:  if (frame_end) state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: if (rx_done || to_hit) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Transmit: frames chain directly on the tick that ends the previous stop bit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_tx     <= 1'b1;
      tx_run   <= 1'b0;
      tx_frame <= '1;
      tx_bit   <= '0;
      tx_sub   <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      reg_op   <= '0;
    end else if (state == ST_IDLE) begin
      o_tx   <= 1'b1;
      tx_run <= 1'b0;
      if (i_start) begin
        reg_a  <= i_datoa;
        reg_b  <= i_datob;
        reg_op <= SIZEDATA'(i_opcode);
      end
    end else if (state != ST_WAIT_RES && tick) begin
      if (!tx_run) begin
        tx_run   <= 1'b1;
        tx_frame <= {1'b1, reg_a};
        o_tx     <= 1'b0;
        tx_bit   <= '0;
        tx_sub   <= '0;
      end else if (tx_sub != SUB_LAST) begin
        tx_sub <= tx_sub + 1'b1;
      end else begin
        tx_sub <= '0;
        if (tx_bit != TX_STOP) begin
          tx_bit   <= tx_bit + 1'b1;
          o_tx     <= tx_frame[0];
          tx_frame <= {1'b1, tx_frame[SIZEDATA:1]};
        end else if (state == ST_SEND_OP) begin
          tx_run <= 1'b0;
          o_tx   <= 1'b1;
        end else begin
          tx_bit   <= '0;
          tx_frame <= {1'b1, (state == ST_SEND_A) ? reg_b : reg_op};
          o_tx     <= 1'b0;
        end
      end
    end
  end

  // Receive: armed from the opcode stop bit; a start must still be low 7 ticks after the edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_armed <= 1'b0;
      rx_chk   <= 1'b0;
      rx_conf  <= 1'b0;
      rx_sub   <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      if (state == ST_IDLE || rx_done || to_hit) rx_armed <= 1'b0;
      else if (state == ST_SEND_OP && tick && tx_run && tx_sub == SUB_LAST && tx_bit == RX_STOP)
        rx_armed <= 1'b1;

      if (!rx_armed || state == ST_IDLE) begin
        rx_chk  <= 1'b0;
        rx_conf <= 1'b0;
      end else if (!rx_chk && !rx_conf) begin
        if (rx_d && !rx_s2) begin
          rx_chk <= 1'b1;
          rx_sub <= '0;
        end
      end else if (tick) begin
        if (rx_chk) begin
          if (rx_sub == START_CHK) begin
            rx_chk  <= 1'b0;
            rx_conf <= !rx_s2;
            rx_sub  <= '0;
            rx_bit  <= '0;
          end else begin
            rx_sub <= rx_sub + 1'b1;
          end
        end else if (rx_sub == SUB_LAST) begin
          rx_sub <= '0;
          if (rx_bit != RX_STOP) begin
            rx_byte <= {rx_s2, rx_byte[SIZEDATA-1:1]};
            rx_bit  <= rx_bit + 1'b1;
          end
        end else begin
          rx_sub <= rx_sub + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      to_cnt      <= '0;
      o_result    <= '0;
      o_valid     <= 1'b0;
      o_timeout   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_timeout   <= 1'b0;
      o_frame_err <= 1'b0;
      if (state != ST_WAIT_RES)     to_cnt <= '0;
      else if (tick && !rx_conf)    to_cnt <= to_cnt + 1'b1;
      if (state == ST_WAIT_RES) begin
        if (rx_done) begin
          if (rx_s2) begin
            o_result <= rx_byte;
            o_valid  <= 1'b1;
          end else begin
            o_frame_err <= 1'b1;
          end
        end else if (to_hit) begin
          o_timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_uart_host.sv
// Randomised bench: decodes the host's serial output, answers as an ALU would, and checks outcomes.
`timescale 1ns/1ps
module tb_alu_uart_host;
  import alu_uart_pkg::*;

  localparam int TD     = 4;
  localparam int TO     = 700;
  localparam int BITC   = 16 * TD;
  localparam int CLK_NS = 10;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] i_datoa = '0;
  logic [7:0] i_datob = '0;
  logic [5:0] i_opcode = '0;
  logic       o_tx, o_busy, o_valid, o_timeout, o_frame_err;
  logic [7:0] o_result;

  alu_uart_host #(.SIZEDATA(8), .SIZEOP(6), .TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_datoa(i_datoa),
    .i_datob(i_datob), .i_opcode(i_opcode), .i_rx(i_rx), .o_tx(o_tx), .o_busy(o_busy),
    .o_result(o_result), .o_valid(o_valid), .o_timeout(o_timeout), .o_frame_err(o_frame_err)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // Line monitor: mid-bit sampling of every frame on o_tx.
  logic [7:0] mon_q[$];
  time        mon_t[$];
  bit         mon_en = 1'b1;

  always begin : tx_monitor
    time t0;
    logic [7:0] b;
    logic st, sp;
    @(negedge o_tx);
    t0 = $time;
    #(BITC * CLK_NS / 2);
    st = o_tx;
    for (int i = 0; i < 8; i++) begin
      #(BITC * CLK_NS);
      b[i] = o_tx;
    end
    #(BITC * CLK_NS);
    sp = o_tx;
    if (mon_en) begin
      mon_q.push_back(b);
      mon_t.push_back(t0);
      chk("tx_start_bit", 32'(st), 32'd0);
      chk("tx_stop_bit", 32'(sp), 32'd1);
    end
  end

  int  n_valid = 0, n_to = 0, n_fe = 0;
  time t_to = 0;
  always @(posedge o_valid) n_valid++;
  always @(posedge o_frame_err) n_fe++;
  always @(posedge o_timeout) begin
    n_to++;
    t_to = $time;
  end

  logic [7:0] exp_result = 8'h00;
  logic [5:0] ops[8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

  task automatic rx_bit_out(input logic v);
    i_rx = v;
    repeat (BITC) @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_bit_out(1'b0);
    for (int i = 0; i < 8; i++) rx_bit_out(b[i]);
    rx_bit_out(stop);
    i_rx = 1'b1;
  endtask

  // mode 0: good response, 1: stop bit low, 2: silent with glitch and a stray start.
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input int mode, input logic [7:0] resp);
    logic [7:0] prev;
    int nv, nt, nf, guard;
    time t_acc;
    prev = exp_result;
    mon_q.delete();
    mon_t.delete();
    @(posedge i_clock);
    #1;
    i_datoa = a; i_datob = b; i_opcode = op; i_start = 1'b1;
    @(posedge i_clock);
    t_acc = $time;
    #1 i_start = 1'b0;
    chk("busy_after_accept", 32'(o_busy), 32'd1);
    if (mode == 2) begin
      repeat ((160 + 30) * TD) @(posedge i_clock);
      #1 i_start = 1'b1; i_datoa = ~a;
      @(posedge i_clock);
      #1 i_start = 1'b0;
    end
    guard = 0;
    while (mon_q.size() < 3 && guard < 700 * TD) begin
      @(posedge i_clock);
      guard++;
    end
    chk("frames_seen", 32'(mon_q.size()), 32'd3);
    if (mon_q.size() >= 3) begin
      chk("frame_a", 32'(mon_q[0]), 32'(a));
      chk("frame_b", 32'(mon_q[1]), 32'(b));
      chk("frame_op", 32'(mon_q[2]), {26'd0, op});
      chk("frame_spacing_ab", 32'(mon_t[1] - mon_t[0]), 32'(160 * TD * CLK_NS));
      chk("frame_spacing_bo", 32'(mon_t[2] - mon_t[1]), 32'(160 * TD * CLK_NS));
      chk("first_start_lat", 32'((mon_t[0] > t_acc) && (mon_t[0] - t_acc <= TD * CLK_NS)), 32'd1);
    end
    nv = n_valid; nt = n_to; nf = n_fe;
    repeat ((10 + $urandom_range(0, 30)) * TD) @(posedge i_clock);
    #1;
    if (mode == 0) send_byte(resp, 1'b1);
    else if (mode == 1) send_byte(resp, 1'b0);
    else begin
      i_rx = 1'b0;
      repeat (3 * TD) @(posedge i_clock);
      #1 i_rx = 1'b1;
    end
    guard = 0;
    while ((n_valid + n_to + n_fe) == (nv + nt + nf) && guard < (TO + 300) * TD) begin
      @(posedge i_clock);
      guard++;
    end
    chk("outcome_seen", 32'((n_valid + n_to + n_fe) - (nv + nt + nf)), 32'd1);
    @(posedge i_clock);
    #1;
    chk("busy_after_outcome", 32'(o_busy), 32'd0);
    chk("valid_count", 32'(n_valid - nv), (mode == 0) ? 32'd1 : 32'd0);
    chk("frame_err_count", 32'(n_fe - nf), (mode == 1) ? 32'd1 : 32'd0);
    chk("timeout_count", 32'(n_to - nt), (mode == 2) ? 32'd1 : 32'd0);
    if (mode == 0) exp_result = resp;
    chk("result", 32'(o_result), 32'(exp_result));
    if (mode != 0) chk("result_kept", 32'(o_result), 32'(prev));
    if (mode == 2 && mon_t.size() >= 3)
      chk("timeout_time", 32'(t_to - mon_t[2]), 32'((160 + TO) * TD * CLK_NS));
    chk("frames_total", 32'(mon_q.size()), 32'd3);
  endtask

  initial begin
    logic [7:0] a, b;
    logic [5:0] op;

    repeat (5) @(posedge i_clock);
    #1;
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_pulses", 32'(o_valid | o_timeout | o_frame_err), 32'd0);
    i_reset = 1'b1;
    repeat (50) @(posedge i_clock);
    #1;
    chk("idle_tx", 32'(o_tx), 32'd1);
    chk("idle_no_frames", 32'(mon_q.size()), 32'd0);

    do_txn(8'h05, 8'h03, OP_ADD, 0, alu_ref(8'h05, 8'h03, OP_ADD));
    do_txn(8'($urandom), 8'($urandom), ops[$urandom_range(0, 7)], 2, 8'h00);
    do_txn(8'($urandom), 8'($urandom), ops[$urandom_range(0, 7)], 1, 8'h5A);

    // Abort mid SEND_B, then a clean transaction.
    @(posedge i_clock);
    #1;
    i_datoa = 8'hA5; i_datob = 8'h3C; i_opcode = OP_XOR; i_start = 1'b1;
    @(posedge i_clock);
    #1 i_start = 1'b0;
    repeat ((160 + 40) * TD) @(posedge i_clock);
    mon_en = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    chk("abort_tx", 32'(o_tx), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_result", 32'(o_result), 32'd0);
    exp_result = 8'h00;
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    repeat (12 * BITC) @(posedge i_clock);
    #1;
    chk("post_abort_tx", 32'(o_tx), 32'd1);
    mon_q.delete();
    mon_t.delete();
    mon_en = 1'b1;

    do_txn(8'hF0, 8'h10, OP_SUB, 0, alu_ref(8'hF0, 8'h10, OP_SUB));
    for (int k = 0; k < 5; k++) begin
      a  = 8'($urandom);
      b  = 8'($urandom_range(0, 9));
      op = ops[$urandom_range(0, 7)];
      do_txn(a, b, op, 0, alu_ref(a, b, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
